cv32e40p_tmr_scrub_regfile: RTL and testbench

// - Write side of TMR protection: stores DEPTH words three times each and returns the bitwise-majority vote on read.
// - Background scrubber walks all entries, rewrites any divergent copy with the voted value and counts corrections.
// - Used for fault-tolerant CSR/state storage; a fault-injection port supports fault-campaign testing.

---
 rtl/cv32e40p_tmr_pkg.sv | 29 ++
 rtl/cv32e40p_tmr_scrub_fsm.sv | 94 +++++++++
 rtl/cv32e40p_tmr_scrub_regfile.sv | 152 +++++++++++++++
 tb/tb_cv32e40p_tmr_scrub_regfile.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_tmr_pkg.sv
// Shared types and the triple-modular-redundancy vote helper.
package cv32e40p_tmr_pkg;

  // Widest word the vote helper handles; callers zero-extend narrower words.
  localparam int unsigned TMR_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    FIX  = 2'd2
  } scrub_state_e;

  typedef struct packed {
    logic [TMR_MAX_W-1:0] v;       // bitwise majority
    logic                 err;     // copies not all identical
    logic                 uncorr;  // no two copies agree
  } tmr_vote_t;

  function automatic tmr_vote_t tmr_vote(input logic [TMR_MAX_W-1:0] a,
                                         input logic [TMR_MAX_W-1:0] b,
                                         input logic [TMR_MAX_W-1:0] c);
    tmr_vote_t r;
    r.v      = (a & b) | (a & c) | (b & c);
    r.err    = !((a == b) && (b == c));
    r.uncorr = (a != b) && (a != c) && (b != c);
    return r;
  endfunction

endpackage

// File: rtl/cv32e40p_tmr_scrub_fsm.sv
// Background scrub sequencer: interval timer, entry pointer and IDLE/READ/FIX state.
// Captures the vote of the pointed entry in READ and requests the repair in FIX.
module cv32e40p_tmr_scrub_fsm
  import cv32e40p_tmr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned SCRUB_INTERVAL = 64,
  localparam int unsigned AW            = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scrub_en_i,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic                  inj_hit_i,
  input  logic [AW-1:0]         inj_addr_i,
  input  logic [DATA_WIDTH-1:0] vote_v_i,
  input  logic                  vote_err_i,
  input  logic                  vote_uncorr_i,
  output logic [AW-1:0]         scrub_addr_o,
  output logic                  fix_en_o,
  output logic [DATA_WIDTH-1:0] fix_data_o,
  output logic                  fix_uncorr_o,
  output logic                  busy_o
);

  localparam int unsigned TW = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;

  scrub_state_e          state_q, state_d;
  logic [TW-1:0]         timer_q;
  logic [AW-1:0]         ptr_q;
  logic [DATA_WIDTH-1:0] v_q;
  logic                  err_q, uncorr_q, abort_q;
  logic                  timer_done;
  logic                  abort;

  assign timer_done = (timer_q == TW'(SCRUB_INTERVAL - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: a step is always READ then FIX, even if scrubbing is disabled mid-step
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (scrub_en_i && timer_done) state_d = READ;
      READ:    state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Timer, pointer and captured vote; a write landing on the entry during READ is remembered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_q  <= '0;
      ptr_q    <= '0;
      v_q      <= '0;
      err_q    <= 1'b0;
      uncorr_q <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!scrub_en_i || timer_done) timer_q <= '0;
          else                           timer_q <= timer_q + 1'b1;
        end
        READ: begin
          v_q      <= vote_v_i;
          err_q    <= vote_err_i;
          uncorr_q <= vote_uncorr_i;
          abort_q  <= we_i && (waddr_i == ptr_q);
        end
        FIX:     ptr_q <= ptr_q + 1'b1;
        default: ;
      endcase
    end
  end

  // Outputs: the repair is dropped if a functional write or injection touches the entry
  always_comb begin
    abort        = abort_q || (we_i && (waddr_i == ptr_q)) || (inj_hit_i && (inj_addr_i == ptr_q));
    fix_en_o     = (state_q == FIX) && err_q && !abort;
    fix_uncorr_o = (state_q == FIX) && uncorr_q && !abort;
    fix_data_o   = v_q;
    scrub_addr_o = ptr_q;
    busy_o       = (state_q != IDLE);
  end

endmodule

// File: rtl/cv32e40p_tmr_scrub_regfile.sv
// Triplicated register file with voted reads, fault injection and background scrubbing.
module cv32e40p_tmr_scrub_regfile
  import cv32e40p_tmr_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,  // must not exceed TMR_MAX_W
  parameter int unsigned DEPTH          = 8,
  parameter int unsigned SCRUB_INTERVAL = 64,
  parameter int unsigned CNT_WIDTH      = 16,
  localparam int unsigned AW            = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rvalid_o,
  output logic                  rerr_o,
  input  logic                  scrub_en_i,
  output logic                  scrub_busy_o,
  input  logic                  inj_valid_i,
  input  logic [1:0]            inj_copy_i,
  input  logic [AW-1:0]         inj_addr_i,
  input  logic [DATA_WIDTH-1:0] inj_mask_i,
  input  logic                  clr_i,
  output logic [CNT_WIDTH-1:0]  corr_cnt_o,
  output logic                  uncorr_o,
  output logic [AW-1:0]         uncorr_addr_o
);

  logic                       inj_hit;
  logic [AW-1:0]              scrub_addr;
  logic                       fix_en, fix_uncorr;
  logic [DATA_WIDTH-1:0]      fix_data;
  logic [2:0][DATA_WIDTH-1:0] rd_word, sc_word;
  tmr_vote_t                  rd_vote, sc_vote;

  logic [DATA_WIDTH-1:0]      rdata_q;
  logic                       rvalid_q, rerr_q;
  logic [CNT_WIDTH-1:0]       corr_cnt_q;
  logic                       uncorr_q;
  logic [AW-1:0]              uncorr_addr_q;

  // Copy select 3 is a no-op strobe
  assign inj_hit = inj_valid_i && (inj_copy_i != 2'd3);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_copy
      logic [DATA_WIDTH-1:0] mem_q [DEPTH];
      logic [DATA_WIDTH-1:0] inj_base;

      // Injection flips bits of whatever the entry is about to hold, including a same-cycle write
      assign inj_base = (we_i && (waddr_i == inj_addr_i)) ? wdata_i : mem_q[inj_addr_i];

      // Copy update: scrub fix, then functional write, then injection (last assignment wins)
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
          if (fix_en) mem_q[scrub_addr] <= fix_data;
          if (we_i)   mem_q[waddr_i]    <= wdata_i;
          if (inj_hit && (inj_copy_i == 2'(gi))) mem_q[inj_addr_i] <= inj_base ^ inj_mask_i;
        end
      end

      assign rd_word[gi] = mem_q[raddr_i];
      assign sc_word[gi] = mem_q[scrub_addr];
    end
  endgenerate

  assign rd_vote = tmr_vote(TMR_MAX_W'(rd_word[0]), TMR_MAX_W'(rd_word[1]), TMR_MAX_W'(rd_word[2]));
  assign sc_vote = tmr_vote(TMR_MAX_W'(sc_word[0]), TMR_MAX_W'(sc_word[1]), TMR_MAX_W'(sc_word[2]));

  // Zero-extension bits of the vote and the read-side uncorr flag carry no information
  generate
    if (DATA_WIDTH < TMR_MAX_W) begin : g_pad
      logic unused_vote_bits;
      assign unused_vote_bits = rd_vote.uncorr ^ (^rd_vote.v[TMR_MAX_W-1:DATA_WIDTH])
                              ^ (^sc_vote.v[TMR_MAX_W-1:DATA_WIDTH]);
    end else begin : g_nopad
      logic unused_vote_bits;
      assign unused_vote_bits = rd_vote.uncorr;
    end
  endgenerate

  cv32e40p_tmr_scrub_fsm #(
    .DATA_WIDTH    (DATA_WIDTH),
    .DEPTH         (DEPTH),
    .SCRUB_INTERVAL(SCRUB_INTERVAL)
  ) u_scrub_fsm (
    .clk          (clk),
    .rst_n        (rst_n),
    .scrub_en_i   (scrub_en_i),
    .we_i         (we_i),
    .waddr_i      (waddr_i),
    .inj_hit_i    (inj_hit),
    .inj_addr_i   (inj_addr_i),
    .vote_v_i     (sc_vote.v[DATA_WIDTH-1:0]),
    .vote_err_i   (sc_vote.err),
    .vote_uncorr_i(sc_vote.uncorr),
    .scrub_addr_o (scrub_addr),
    .fix_en_o     (fix_en),
    .fix_data_o   (fix_data),
    .fix_uncorr_o (fix_uncorr),
    .busy_o       (scrub_busy_o)
  );

  // Registered voted read; storage is sampled before this cycle's writes land
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
    end else begin
      rvalid_q <= re_i;
      if (re_i) begin
        rdata_q <= rd_vote.v[DATA_WIDTH-1:0];
        rerr_q  <= rd_vote.err;
      end
    end
  end

  // Correction statistics; clear beats a simultaneous update
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      corr_cnt_q    <= '0;
      uncorr_q      <= 1'b0;
      uncorr_addr_q <= '0;
    end else if (clr_i) begin
      corr_cnt_q    <= '0;
      uncorr_q      <= 1'b0;
      uncorr_addr_q <= '0;
    end else begin
      if (fix_en && (corr_cnt_q != '1)) corr_cnt_q <= corr_cnt_q + 1'b1;
      if (fix_uncorr && !uncorr_q) begin
        uncorr_q      <= 1'b1;
        uncorr_addr_q <= scrub_addr;
      end
    end
  end

  assign rdata_o       = rdata_q;
  assign rvalid_o      = rvalid_q;
  assign rerr_o        = rerr_q;
  assign corr_cnt_o    = corr_cnt_q;
  assign uncorr_o      = uncorr_q;
  assign uncorr_addr_o = uncorr_addr_q;

endmodule

// File: tb/tb_cv32e40p_tmr_scrub_regfile.sv
// Bench for the TMR scrub register file: behavioural model plus directed and random stimulus.
module tb_cv32e40p_tmr_scrub_regfile;

  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int AW = 3;
  localparam int SI = 4;
  localparam int CW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, we_i, re_i, scrub_en_i, inj_valid_i, clr_i;
  logic [AW-1:0] waddr_i, raddr_i, inj_addr_i, uncorr_addr_o;
  logic [DW-1:0] wdata_i, inj_mask_i, rdata_o;
  logic [1:0]    inj_copy_i;
  logic          rvalid_o, rerr_o, scrub_busy_o, uncorr_o;
  logic [CW-1:0] corr_cnt_o;

  cv32e40p_tmr_scrub_regfile #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .SCRUB_INTERVAL(SI), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .re_i(re_i), .raddr_i(raddr_i), .rdata_o(rdata_o), .rvalid_o(rvalid_o), .rerr_o(rerr_o),
    .scrub_en_i(scrub_en_i), .scrub_busy_o(scrub_busy_o), .inj_valid_i(inj_valid_i),
    .inj_copy_i(inj_copy_i), .inj_addr_i(inj_addr_i), .inj_mask_i(inj_mask_i), .clr_i(clr_i),
    .corr_cnt_o(corr_cnt_o), .uncorr_o(uncorr_o), .uncorr_addr_o(uncorr_addr_o)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m [3][DEPTH];
  logic [DW-1:0] exp_rdata = '0;
  bit            exp_rvalid = 0, exp_rerr = 0, exp_busy = 0, exp_unc = 0;
  int            exp_cnt = 0, exp_uaddr = 0;
  // scrub progress: stage 0 waiting, 1 sampling, 2 repairing
  int            stage = 0, idle_cycles = 0, cursor = 0;
  logic [DW-1:0] snap_v;
  bit            snap_err, snap_unc, snap_hit;
  bit            cmp_en = 0;

  function automatic logic [DW-1:0] majority(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                             input logic [DW-1:0] c);
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) r[i] = (int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2;
    return r;
  endfunction

  task automatic model_step();
    logic [DW-1:0] a, b, c;
    bit do_fix, do_unc, inj_eff, hit;
    int fix_at;
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) for (int e = 0; e < DEPTH; e++) m[k][e] = '0;
      exp_rdata = '0; exp_rvalid = 0; exp_rerr = 0; exp_busy = 0;
      exp_cnt = 0; exp_unc = 0; exp_uaddr = 0;
      stage = 0; idle_cycles = 0; cursor = 0;
      snap_v = '0; snap_err = 0; snap_unc = 0; snap_hit = 0;
      return;
    end
    inj_eff = inj_valid_i && (inj_copy_i != 2'd3);
    exp_rvalid = re_i;
    if (re_i) begin
      a = m[0][raddr_i]; b = m[1][raddr_i]; c = m[2][raddr_i];
      exp_rdata = majority(a, b, c);
      exp_rerr  = !(a == b && b == c);
    end
    do_fix = 0; do_unc = 0; fix_at = 0;
    if (stage == 0) begin
      if (!scrub_en_i) idle_cycles = 0;
      else if (idle_cycles == SI - 1) begin idle_cycles = 0; stage = 1; end
      else idle_cycles++;
    end else if (stage == 1) begin
      a = m[0][cursor]; b = m[1][cursor]; c = m[2][cursor];
      snap_v = majority(a, b, c);
      snap_err = !(a == b && b == c);
      snap_unc = (a != b) && (a != c) && (b != c);
      snap_hit = we_i && (int'(waddr_i) == cursor);
      stage = 2;
    end else begin
      hit = snap_hit || (we_i && int'(waddr_i) == cursor) || (inj_eff && int'(inj_addr_i) == cursor);
      do_fix = !hit && snap_err;
      do_unc = !hit && snap_unc;
      fix_at = cursor;
      cursor = (cursor + 1) % DEPTH;
      stage = 0;
    end
    if (do_fix) for (int k = 0; k < 3; k++) m[k][fix_at] = snap_v;
    if (we_i) for (int k = 0; k < 3; k++) m[k][waddr_i] = wdata_i;
    if (inj_eff) m[inj_copy_i][inj_addr_i] = m[inj_copy_i][inj_addr_i] ^ inj_mask_i;
    if (clr_i) begin
      exp_cnt = 0; exp_unc = 0; exp_uaddr = 0;
    end else begin
      if (do_fix && exp_cnt < (1 << CW) - 1) exp_cnt++;
      if (do_unc && !exp_unc) begin exp_unc = 1; exp_uaddr = fix_at; end
    end
    exp_busy = (stage != 0);
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Every cycle: DUT outputs against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_rvalid", 64'(rvalid_o), 64'(exp_rvalid));
      if (exp_rvalid) begin
        chk("cmp_rdata", 64'(rdata_o), 64'(exp_rdata));
        chk("cmp_rerr", 64'(rerr_o), 64'(exp_rerr));
      end
      chk("cmp_busy", 64'(scrub_busy_o), 64'(exp_busy));
      chk("cmp_cnt", 64'(corr_cnt_o), 64'(exp_cnt));
      chk("cmp_uncorr", 64'(uncorr_o), 64'(exp_unc));
      chk("cmp_uaddr", 64'(uncorr_addr_o), 64'(exp_uaddr));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_write(input int a, input logic [DW-1:0] d);
    we_i = 1; waddr_i = AW'(a); wdata_i = d; tick(); we_i = 0;
  endtask

  task automatic do_read(input int a);
    re_i = 1; raddr_i = AW'(a); tick(); re_i = 0;
  endtask

  task automatic do_inj(input int cp, input int a, input logic [DW-1:0] mask);
    inj_valid_i = 1; inj_copy_i = 2'(cp); inj_addr_i = AW'(a); inj_mask_i = mask;
    tick(); inj_valid_i = 0;
  endtask

  task automatic do_clr();
    clr_i = 1; tick(); clr_i = 0;
  endtask

  // Advance until the current cycle is a repair cycle (optionally at a given entry)
  task automatic wait_fix(input int a, input bit any_entry, input string nm);
    int n = 0;
    while (!(stage == 2 && (any_entry || cursor == a)) && n < 400) begin tick(); n++; end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL %s: no repair cycle within %0d cycles (required one)", nm, n);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 0; we_i = 0; re_i = 0; scrub_en_i = 0; inj_valid_i = 0; clr_i = 0;
    waddr_i = '0; raddr_i = '0; inj_addr_i = '0; wdata_i = '0; inj_mask_i = '0; inj_copy_i = 2'd3;
    idle(2);
    cmp_en = 1;
    chk("rst_rvalid", 64'(rvalid_o), 64'd0);
    chk("rst_cnt", 64'(corr_cnt_o), 64'd0);
    chk("rst_busy", 64'(scrub_busy_o), 64'd0);
    rst_n = 1;
    tick();

    // basic write / read
    do_write(3, 32'hA5A5_0001);
    do_read(3);
    chk("wr_rd_data", 64'(rdata_o), 64'hA5A5_0001);
    chk("wr_rd_valid", 64'(rvalid_o), 64'd1);
    chk("wr_rd_err", 64'(rerr_o), 64'd0);

    // single-copy fault is masked but flagged, then scrubbed
    do_inj(1, 3, 32'h0000_00FF);
    do_read(3);
    chk("inj_rd_data", 64'(rdata_o), 64'hA5A5_0001);
    chk("inj_rd_err", 64'(rerr_o), 64'd1);
    scrub_en_i = 1; idle(56); scrub_en_i = 0; idle(3);
    chk("sweep_cnt", 64'(corr_cnt_o), 64'd1);
    do_read(3);
    chk("sweep_rd_err", 64'(rerr_o), 64'd0);
    chk("sweep_rd_data", 64'(rdata_o), 64'hA5A5_0001);

    // uncorrectable entry
    do_clr();
    do_inj(0, 5, 32'h1);
    do_inj(1, 5, 32'h2);
    scrub_en_i = 1; idle(56); scrub_en_i = 0; idle(3);
    chk("unc_flag", 64'(uncorr_o), 64'd1);
    chk("unc_addr", 64'(uncorr_addr_o), 64'd5);
    do_read(5);
    chk("unc_rd_data", 64'(rdata_o), 64'd0);
    chk("unc_rd_err", 64'(rerr_o), 64'd0);
    do_clr();
    chk("clr_flag", 64'(uncorr_o), 64'd0);
    chk("clr_addr", 64'(uncorr_addr_o), 64'd0);
    chk("clr_cnt", 64'(corr_cnt_o), 64'd0);

    // write during the repair cycle aborts the fix
    do_inj(2, 2, 32'h0000_00F0);
    scrub_en_i = 1;
    wait_fix(2, 0, "abort_wait");
    we_i = 1; waddr_i = 3'd2; wdata_i = 32'h1234; tick(); we_i = 0;
    scrub_en_i = 0; idle(3);
    chk("abort_cnt", 64'(corr_cnt_o), 64'd0);
    do_read(2);
    chk("abort_rd_data", 64'(rdata_o), 64'h1234);
    chk("abort_rd_err", 64'(rerr_o), 64'd0);

    // counter saturation across the pointer wrap
    do_clr();
    do_inj(0, 0, 32'h10);
    do_inj(1, 1, 32'h20);
    do_inj(2, 4, 32'h40);
    do_inj(0, 6, 32'h80);
    do_inj(1, 7, 32'h100);
    scrub_en_i = 1; idle(56); scrub_en_i = 0; idle(3);
    chk("sat_cnt", 64'(corr_cnt_o), 64'd3);

    // randomized traffic, all paths concurrently
    for (int i = 0; i < 3000; i++) begin
      scrub_en_i  = ($urandom_range(0, 9) != 0);
      we_i        = ($urandom_range(0, 9) < 3);
      waddr_i     = AW'($urandom_range(0, DEPTH - 1));
      wdata_i     = $urandom;
      re_i        = ($urandom_range(0, 1) == 1);
      raddr_i     = AW'($urandom_range(0, DEPTH - 1));
      inj_valid_i = ($urandom_range(0, 19) < 3);
      inj_copy_i  = 2'($urandom_range(0, 3));
      inj_addr_i  = AW'($urandom_range(0, DEPTH - 1));
      inj_mask_i  = ($urandom_range(0, 1) == 1) ? (32'h1 << $urandom_range(0, 31)) : $urandom;
      clr_i       = ($urandom_range(0, 99) < 3);
      tick();
    end
    we_i = 0; re_i = 0; inj_valid_i = 0; clr_i = 0;

    // reset in the middle of a repair
    do_inj(0, 1, 32'hFFFF);
    do_inj(2, 6, 32'h0F0F);
    scrub_en_i = 1;
    wait_fix(0, 1, "rst_wait");
    rst_n = 0; scrub_en_i = 0; tick();
    chk("mrst_rvalid", 64'(rvalid_o), 64'd0);
    chk("mrst_rdata", 64'(rdata_o), 64'd0);
    chk("mrst_busy", 64'(scrub_busy_o), 64'd0);
    chk("mrst_cnt", 64'(corr_cnt_o), 64'd0);
    chk("mrst_uncorr", 64'(uncorr_o), 64'd0);
    chk("mrst_uaddr", 64'(uncorr_addr_o), 64'd0);
    rst_n = 1;
    for (int a = 0; a < DEPTH; a++) begin
      do_read(a);
      chk("mrst_rd_data", 64'(rdata_o), 64'd0);
      chk("mrst_rd_err", 64'(rerr_o), 64'd0);
    end

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
